odd_seq_checker: RTL and testbench

ODD_SEQ_CHECKER -- requirements
Module: odd_seq_checker

---
 rtl/odd_seq_checker.sv | 108 ++++++++++
 tb/tb_odd_seq_checker.sv | 337 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/odd_seq_checker.sv
// Tracks a free-running odd counter (step +2, mod 256): acquires lock after LOCK_CNT
// consecutive correct samples, flags every bad sample, and counts matches while locked.
module odd_seq_checker #(
    parameter int unsigned LOCK_CNT = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    output logic        locked,
    output logic        err_pulse,
    output logic [7:0]  err_count,
    output logic [15:0] match_count,
    output logic [7:0]  expected
);

    localparam logic [3:0] LockCnt = 4'(LOCK_CNT);

    typedef enum logic [1:0] {StIdle, StAcq, StLocked, StLost} state_e;

    state_e     state;
    logic [3:0] acq_cnt;

    logic       is_odd;
    logic       is_match;
    logic [7:0] next_exp;
    logic [7:0] err_count_inc;
    logic [3:0] acq_cnt_inc;

    always_comb begin
        is_odd        = in_data[0];
        is_match      = (in_data == expected);
        next_exp      = in_data + 8'd2;
        err_count_inc = (err_count == 8'hFF) ? err_count : err_count + 8'd1;
        acq_cnt_inc   = acq_cnt + 4'd1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= StIdle;
            acq_cnt     <= 4'd0;
            locked      <= 1'b0;
            err_pulse   <= 1'b0;
            err_count   <= 8'd0;
            match_count <= 16'd0;
            expected    <= 8'd0;
        end else begin
            err_pulse <= 1'b0;
            case (state)
                StIdle, StLost: begin
                    if (in_valid) begin
                        if (is_odd) begin
                            state    <= StAcq;
                            acq_cnt  <= 4'd1;
                            expected <= next_exp;
                        end else begin
                            err_pulse <= 1'b1;
                            err_count <= err_count_inc;
                        end
                    end
                end
                StAcq: begin
                    if (in_valid) begin
                        if (is_match) begin
                            acq_cnt  <= acq_cnt_inc;
                            expected <= next_exp;
                            if (acq_cnt_inc == LockCnt) begin
                                state  <= StLocked;
                                locked <= 1'b1;
                            end
                        end else begin
                            err_pulse <= 1'b1;
                            err_count <= err_count_inc;
                            // Restart acquisition from the offending sample itself
                            if (is_odd) begin
                                acq_cnt  <= 4'd1;
                                expected <= next_exp;
                            end else begin
                                state   <= StIdle;
                                acq_cnt <= 4'd0;
                            end
                        end
                    end
                end
                StLocked: begin
                    if (in_valid) begin
                        if (is_match) begin
                            expected    <= next_exp;
                            match_count <= match_count + 16'd1;
                        end else begin
                            // expected is kept so the lost position stays visible
                            state     <= StLost;
                            locked    <= 1'b0;
                            err_pulse <= 1'b1;
                            err_count <= err_count_inc;
                        end
                    end
                end
                default: begin
                    state   <= StIdle;
                    locked  <= 1'b0;
                    acq_cnt <= 4'd0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_odd_seq_checker.sv
// Directed bench for odd_seq_checker: lock, wrap, loss/relock, valid gaps,
// error saturation and asynchronous reset.
module tb_odd_seq_checker;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        locked;
    logic        err_pulse;
    logic [7:0]  err_count;
    logic [15:0] match_count;
    logic [7:0]  expected;

    int tests_run;
    int tests_failed;

    odd_seq_checker #(.LOCK_CNT(4)) dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_data     (in_data),
        .locked      (locked),
        .err_pulse   (err_pulse),
        .err_count   (err_count),
        .match_count (match_count),
        .expected    (expected)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Present one sample for one rising edge; return 1 time unit after that edge.
    task automatic send(input logic v, input logic [7:0] d);
        in_valid = v;
        in_data  = d;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset    = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'd0;
        #2;
        reset = 1'b1;
        @(posedge clk);
        #1;
        tests_run++;
        if (locked !== 1'b0 || err_pulse !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_flags: locked=%b err_pulse=%b, want 0 0", locked, err_pulse);
        end
        tests_run++;
        if (err_count !== 8'd0 || match_count !== 16'd0 || expected !== 8'd0) begin
            tests_failed++;
            $display("FAIL reset_counts: err=%0d match=%0d exp=%0d, want 0 0 0",
                     err_count, match_count, expected);
        end
        reset = 1'b0;
    endtask

    task automatic test_lock();
        do_reset();
        send(1'b1, 8'd1);
        send(1'b1, 8'd3);
        send(1'b1, 8'd5);
        tests_run++;
        if (locked !== 1'b0) begin
            tests_failed++;
            $display("FAIL lock_early: locked=%b after 3 samples, want 0", locked);
        end
        send(1'b1, 8'd7);
        tests_run++;
        if (locked !== 1'b1 || expected !== 8'd9) begin
            tests_failed++;
            $display("FAIL lock_at_7: locked=%b exp=%0d, want 1 9", locked, expected);
        end
        send(1'b1, 8'd9);
        tests_run++;
        if (match_count !== 16'd1 || err_count !== 8'd0) begin
            tests_failed++;
            $display("FAIL lock_match9: match=%0d err=%0d, want 1 0", match_count, err_count);
        end
    endtask

    task automatic test_wrap();
        int errs;
        do_reset();
        errs = 0;
        send(1'b1, 8'd247);
        send(1'b1, 8'd249);
        send(1'b1, 8'd251);
        send(1'b1, 8'd253);
        send(1'b1, 8'd255);
        if (err_pulse !== 1'b0) errs++;
        tests_run++;
        if (expected !== 8'd1) begin
            tests_failed++;
            $display("FAIL wrap_255: exp=%0d, want 1", expected);
        end
        send(1'b1, 8'd1);
        if (err_pulse !== 1'b0) errs++;
        send(1'b1, 8'd3);
        if (err_pulse !== 1'b0) errs++;
        tests_run++;
        if (errs != 0 || err_count !== 8'd0) begin
            tests_failed++;
            $display("FAIL wrap_noerr: pulses=%0d err=%0d, want 0 0", errs, err_count);
        end
        tests_run++;
        if (expected !== 8'd5 || locked !== 1'b1 || match_count !== 16'd3) begin
            tests_failed++;
            $display("FAIL wrap_after3: exp=%0d locked=%b match=%0d, want 5 1 3",
                     expected, locked, match_count);
        end
    endtask

    task automatic test_acq_restart();
        do_reset();
        send(1'b1, 8'd1);
        send(1'b1, 8'd3);
        send(1'b1, 8'd9);
        tests_run++;
        if (err_pulse !== 1'b1 || expected !== 8'd11 || err_count !== 8'd1) begin
            tests_failed++;
            $display("FAIL acq_odd_miss: pulse=%b exp=%0d err=%0d, want 1 11 1",
                     err_pulse, expected, err_count);
        end
        send(1'b1, 8'd11);
        send(1'b1, 8'd13);
        tests_run++;
        if (locked !== 1'b0) begin
            tests_failed++;
            $display("FAIL acq_restart_early: locked=%b, want 0", locked);
        end
        send(1'b1, 8'd15);
        tests_run++;
        if (locked !== 1'b1) begin
            tests_failed++;
            $display("FAIL acq_restart_lock: locked=%b, want 1", locked);
        end
        do_reset();
        send(1'b1, 8'd1);
        send(1'b1, 8'd3);
        send(1'b1, 8'd6);
        tests_run++;
        if (err_pulse !== 1'b1 || err_count !== 8'd1) begin
            tests_failed++;
            $display("FAIL acq_even_miss: pulse=%b err=%0d, want 1 1", err_pulse, err_count);
        end
        // From IDLE an odd sample must start acquisition silently
        send(1'b1, 8'd7);
        tests_run++;
        if (err_pulse !== 1'b0 || expected !== 8'd9 || err_count !== 8'd1) begin
            tests_failed++;
            $display("FAIL acq_reacquire: pulse=%b exp=%0d err=%0d, want 0 9 1",
                     err_pulse, expected, err_count);
        end
    endtask

    task automatic test_lost_relock();
        do_reset();
        send(1'b1, 8'd13);
        send(1'b1, 8'd15);
        send(1'b1, 8'd17);
        send(1'b1, 8'd19);
        tests_run++;
        if (locked !== 1'b1 || expected !== 8'd21) begin
            tests_failed++;
            $display("FAIL lost_prelock: locked=%b exp=%0d, want 1 21", locked, expected);
        end
        send(1'b1, 8'd40);
        tests_run++;
        if (err_pulse !== 1'b1 || locked !== 1'b0 || expected !== 8'd21 || err_count !== 8'd1)
        begin
            tests_failed++;
            $display("FAIL lost_inject: pulse=%b locked=%b exp=%0d err=%0d, want 1 0 21 1",
                     err_pulse, locked, expected, err_count);
        end
        send(1'b1, 8'd41);
        tests_run++;
        if (err_pulse !== 1'b0 || locked !== 1'b0 || expected !== 8'd43) begin
            tests_failed++;
            $display("FAIL lost_reacq: pulse=%b locked=%b exp=%0d, want 0 0 43",
                     err_pulse, locked, expected);
        end
        send(1'b1, 8'd43);
        send(1'b1, 8'd45);
        tests_run++;
        if (locked !== 1'b0) begin
            tests_failed++;
            $display("FAIL lost_early: locked=%b after 45, want 0", locked);
        end
        send(1'b1, 8'd47);
        tests_run++;
        if (locked !== 1'b1 || err_count !== 8'd1 || match_count !== 16'd0) begin
            tests_failed++;
            $display("FAIL lost_relock: locked=%b err=%0d match=%0d, want 1 1 0",
                     locked, err_count, match_count);
        end
    endtask

    task automatic test_valid_gaps();
        do_reset();
        send(1'b1, 8'd1);
        send(1'b0, 8'd50);
        send(1'b0, 8'd50);
        tests_run++;
        if (err_pulse !== 1'b0 || expected !== 8'd3 || err_count !== 8'd0) begin
            tests_failed++;
            $display("FAIL gap_hold: pulse=%b exp=%0d err=%0d, want 0 3 0",
                     err_pulse, expected, err_count);
        end
        send(1'b1, 8'd3);
        send(1'b0, 8'd8);
        send(1'b1, 8'd5);
        send(1'b0, 8'd8);
        tests_run++;
        if (locked !== 1'b0 || expected !== 8'd7) begin
            tests_failed++;
            $display("FAIL gap_prelock: locked=%b exp=%0d, want 0 7", locked, expected);
        end
        send(1'b1, 8'd7);
        tests_run++;
        if (locked !== 1'b1 || err_count !== 8'd0) begin
            tests_failed++;
            $display("FAIL gap_lock: locked=%b err=%0d, want 1 0", locked, err_count);
        end
        send(1'b0, 8'd100);
        tests_run++;
        if (locked !== 1'b1 || match_count !== 16'd0 || expected !== 8'd9) begin
            tests_failed++;
            $display("FAIL gap_locked_idle: locked=%b match=%0d exp=%0d, want 1 0 9",
                     locked, match_count, expected);
        end
    endtask

    task automatic test_saturate();
        int missed;
        do_reset();
        missed = 0;
        for (int i = 0; i < 300; i++) begin
            send(1'b1, 8'((i * 2) % 256));
            if (err_pulse !== 1'b1) missed++;
            if (i == 253) begin
                tests_run++;
                if (err_count !== 8'd254) begin
                    tests_failed++;
                    $display("FAIL sat_254: err=%0d, want 254", err_count);
                end
            end
        end
        tests_run++;
        if (missed != 0) begin
            tests_failed++;
            $display("FAIL sat_pulses: missing pulses=%0d, want 0", missed);
        end
        tests_run++;
        if (err_count !== 8'd255 || locked !== 1'b0) begin
            tests_failed++;
            $display("FAIL sat_count: err=%0d locked=%b, want 255 0", err_count, locked);
        end
        send(1'b1, 8'd5);
        tests_run++;
        if (err_pulse !== 1'b0 || expected !== 8'd7 || err_count !== 8'd255) begin
            tests_failed++;
            $display("FAIL sat_idle_exit: pulse=%b exp=%0d err=%0d, want 0 7 255",
                     err_pulse, expected, err_count);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        send(1'b1, 8'd2);
        send(1'b1, 8'd11);
        send(1'b1, 8'd13);
        send(1'b1, 8'd15);
        send(1'b1, 8'd17);
        send(1'b1, 8'd19);
        tests_run++;
        if (locked !== 1'b1 || match_count !== 16'd1 || err_count !== 8'd1) begin
            tests_failed++;
            $display("FAIL areset_pre: locked=%b match=%0d err=%0d, want 1 1 1",
                     locked, match_count, err_count);
        end
        #2;
        reset = 1'b1;
        #1;
        tests_run++;
        if (locked !== 1'b0 || err_pulse !== 1'b0) begin
            tests_failed++;
            $display("FAIL areset_flags: locked=%b pulse=%b, want 0 0", locked, err_pulse);
        end
        tests_run++;
        if (err_count !== 8'd0 || match_count !== 16'd0 || expected !== 8'd0) begin
            tests_failed++;
            $display("FAIL areset_counts: err=%0d match=%0d exp=%0d, want 0 0 0",
                     err_count, match_count, expected);
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
        send(1'b1, 8'd11);
        tests_run++;
        if (expected !== 8'd13 || locked !== 1'b0 || err_pulse !== 1'b0 || err_count !== 8'd0)
        begin
            tests_failed++;
            $display("FAIL areset_restart: exp=%0d locked=%b pulse=%b err=%0d, want 13 0 0 0",
                     expected, locked, err_pulse, err_count);
        end
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        test_reset();
        test_lock();
        test_wrap();
        test_acq_restart();
        test_lost_relock();
        test_valid_gaps();
        test_saturate();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
